// File: rtl/pipeline_trace_pkg.sv
// Shared state encoding and timestamp width for the pipeline trace buffer.
// Combinational definitions only; no latency or backpressure.
package pipeline_trace_pkg;

    localparam int TS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/trace_ram.sv
// Trace storage, one write and one read port; read data registered, 1-cycle latency.
// No backpressure: writes and reads are accepted every cycle their enable is high.
module trace_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_dat_d;
    logic [WIDTH-1:0] rd_dat_q;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Triggered capture ring buffer with post-trigger window and oldest-first readout; reads return 1 cycle after rd_req.
// No backpressure: samples are dropped outside capture states; optional timestamps via PIPELINE_TRACE_TS_EN.
module pipeline_trace_buffer
    import pipeline_trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic [DATA_W-1:0]          trig_val,
    input  logic                       smp_valid,
    input  logic [NUM_CH*DATA_W-1:0]   smp_data,
    output logic [1:0]                 state,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [NUM_CH*DATA_W-1:0]   rd_data
`ifdef PIPELINE_TRACE_TS_EN
    ,
    output logic [TS_W-1:0]            rd_ts
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SMP_W = NUM_CH * DATA_W;
`ifdef PIPELINE_TRACE_TS_EN
    localparam int ENT_W = SMP_W + TS_W;
`else
    localparam int ENT_W = SMP_W;
`endif
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [AW-1:0] POST_LDV = AW'(POST_TRIG);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_en, rd_en, trig_hit;
    logic [ENT_W-1:0] ram_wr_dat, ram_rd_dat;

    assign trig_hit = (smp_data[DATA_W-1:0] == trig_val);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        post_cnt_d = post_cnt_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        // arm wins over any capture or readout activity in the same cycle
        if (arm) begin
            state_d    = ST_ARMED;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            post_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    if (smp_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (count_q == FULL) begin
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                        if (state_q == ST_ARMED) begin
                            if (trig_hit) begin
                                if (POST_TRIG > 0) begin
                                    state_d    = ST_POST;
                                    post_cnt_d = POST_LDV;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end
                        end else begin
                            post_cnt_d = post_cnt_q - AW'(1);
                            if (post_cnt_q == AW'(1)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_req && (count_q != '0)) begin
                        rd_en      = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        count_d    = count_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_cnt_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            post_cnt_q <= post_cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef PIPELINE_TRACE_TS_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = arm ? '0 : ts_q + TS_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    // Entry stores the counter value present at its write edge.
    assign ram_wr_dat = {ts_q, smp_data};
    assign rd_ts      = ram_rd_dat[ENT_W-1:SMP_W];
`else
    assign ram_wr_dat = smp_data;
`endif

    trace_ram #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_dat  (ram_wr_dat),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_dat  (ram_rd_dat)
    );

    assign state    = state_q;
    assign done     = (state_q == ST_DONE);
    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = ram_rd_dat[SMP_W-1:0];

endmodule
